vu_frame_ctrl: RTL and testbench
================================

VU_FRAME_CTRL -- requirements
Module: vu_frame_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: level channels per frame, range 1..16.
REQ-002 SHALL have parameter SYNC, default 8'hFF: frame-start byte value.
REQ-003 SHALL have parameter HOLD_FRAMES, default 8: frames a new peak is held before decay starts, range 0..255.
REQ-004 SHALL have parameter DECAY, default 4: per-frame peak decrement after hold expires, range 1..255.
REQ-005 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_data, input, 8: received byte from the UART receiver.
REQ-008 SHALL have port i_dv, input, 1: UART data-valid; a byte is accepted only on its rising edge (i_dv=1 with the registered previous i_dv=0).
REQ-009 SHALL have port i_npxl_rdy, input, 1: pixel controller ready.
REQ-010 SHALL have port o_send, output, 1: one-cycle start pulse to the pixel controller.
REQ-011 SHALL have port o_value, output, 8: display level for the channel being sent.
REQ-012 SHALL have port o_chan, output, 4: index of the channel being sent.
REQ-013 SHALL have port o_rdy, output, 1: high only in IDLE with i_npxl_rdy=1.
REQ-014 SHALL have port o_frame_err, output, 1: one-cycle pulse on a malformed frame.
REQ-015 SHALL have port o_ovr, output, 1: one-cycle pulse when a byte is dropped during SEND.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, UPDATE, SEND, WAIT_LO, WAIT_HI.
REQ-017 IDLE: accepted byte == SYNC -> RECV with byte counter 0; any other byte is ignored, no error.
REQ-018 RECV: accepted byte != SYNC is stored as level[counter], counter increments; after byte index CHANNELS-1 -> UPDATE.
REQ-019 RECV: accepted byte == SYNC -> o_frame_err pulse, counter reset to 0, stay in RECV; stored levels of the aborted frame are discarded.
REQ-020 UPDATE (one cycle), per channel, 8-bit unsigned: if level >= peak, peak := level and hold := HOLD_FRAMES; else if hold > 0, hold := hold-1; else peak := max(level, peak-DECAY), where peak-DECAY saturates at 0.
REQ-021 UPDATE -> SEND with channel index 0.
REQ-022 SEND: while i_npxl_rdy=0, wait; when i_npxl_rdy=1, assert o_send for exactly one cycle with o_value=peak[ch], o_chan=ch, then -> WAIT_LO.
REQ-023 WAIT_LO: wait for i_npxl_rdy=0 (controller drops ready the cycle after o_send), then -> WAIT_HI.
REQ-024 WAIT_HI: on i_npxl_rdy=1, if ch < CHANNELS-1, ch increments and -> SEND; else -> IDLE.
REQ-025 o_value and o_chan SHALL hold their last sent values outside the o_send cycle.
REQ-026 Bytes accepted in UPDATE, SEND, WAIT_LO or WAIT_HI SHALL be dropped with an o_ovr pulse in the same cycle; FSM is unaffected.
REQ-027 i_dv held high for multiple cycles SHALL count as exactly one byte.
REQ-028 Latency: o_send first asserts 2 cycles after the last level byte is accepted, given i_npxl_rdy=1.

Reset
REQ-029 i_rst_n=0 SHALL immediately force: state IDLE; counter, ch, all peak and hold registers 0; o_send=0, o_value=0, o_chan=0, o_frame_err=0, o_ovr=0; previous-i_dv register 0.
REQ-030 Reset asserted mid-frame or mid-SEND SHALL abort without emitting further o_send; the first accepted byte after release is treated as in IDLE.

Verification (CHANNELS=2, HOLD_FRAMES=2, DECAY=16, i_npxl_rdy model: drops 1 cycle after o_send, returns after 10 cycles)
REQ-031 Frame FF,40,80 -> o_send twice: (o_chan=0,o_value=0x40) then (o_chan=1,o_value=0x80); o_rdy returns to 1.
REQ-032 Frames FF,80,00 then three frames FF,10,00 -> channel 0 values 0x80, 0x80, 0x80, 0x70 (hold 2 frames, then decay 16).
REQ-033 Frame FF,40,FF,20,30 -> one o_frame_err pulse at the second FF; sends 0x20, 0x30 only.
REQ-034 Byte 0x55 delivered while in WAIT_LO -> one o_ovr pulse; exactly two o_send pulses for the frame; next frame decoded correctly.
REQ-035 i_rst_n pulsed low after FF,40 -> no o_send; all outputs 0; subsequent FF,11,22 -> sends 0x11, 0x22.
REQ-036 i_dv held high 5 cycles with 0xFF, then bytes 01,02 -> treated as one SYNC; sends 0x01, 0x02.

Source files
------------

// File: rtl/vu_frame_ctrl.sv
// rtl/vu_frame_ctrl.sv - VU meter frame decoder with per-channel peak hold/decay and pixel hand-off
module vu_frame_ctrl #(
  parameter int          CHANNELS    = 2,
  parameter logic [7:0]  SYNC        = 8'hFF,
  parameter int          HOLD_FRAMES = 8,
  parameter int          DECAY       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_dv,
  input  logic       i_npxl_rdy,
  output logic       o_send,
  output logic [7:0] o_value,
  output logic [3:0] o_chan,
  output logic       o_rdy,
  output logic       o_frame_err,
  output logic       o_ovr
);

  localparam int              CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CHANNELS - 1);
  localparam logic [7:0]      HOLD = 8'(HOLD_FRAMES);
  localparam logic [7:0]      DEC  = 8'(DECAY);

  typedef enum logic [2:0] {IDLE, RECV, UPDATE, SEND, WAIT_LO, WAIT_HI} state_t;

  state_t        state, state_nxt;
  logic          dv_q;
  logic          accept;
  logic          is_sync;
  logic          frame_err_nxt;
  logic          ovr_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ch;
  logic [7:0]    level    [CHANNELS];
  logic [7:0]    peak     [CHANNELS];
  logic [7:0]    hold     [CHANNELS];
  logic [7:0]    peak_dec [CHANNELS];
  logic [7:0]    peak_upd [CHANNELS];
  logic [7:0]    hold_upd [CHANNELS];

  assign accept  = i_dv & ~dv_q;
  assign is_sync = (i_data == SYNC);
  assign o_rdy   = (state == IDLE) && i_npxl_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    frame_err_nxt = 1'b0;
    ovr_nxt       = 1'b0;
    case (state)
      IDLE:    if (accept && is_sync) state_nxt = RECV;
      RECV: begin
        if (accept && is_sync)                    frame_err_nxt = 1'b1;
        else if (accept && cnt == LAST)           state_nxt = UPDATE;
      end
      UPDATE: begin
        ovr_nxt   = accept;
        state_nxt = SEND;
      end
      SEND: begin
        ovr_nxt = accept;
        if (i_npxl_rdy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        ovr_nxt = accept;
        if (!i_npxl_rdy) state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        ovr_nxt = accept;
        if (i_npxl_rdy) state_nxt = (ch == LAST) ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // New peak restarts hold; once hold runs out the peak decays toward the live level.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      peak_dec[i] = (peak[i] >= DEC) ? (peak[i] - DEC) : 8'd0;
      peak_upd[i] = peak[i];
      hold_upd[i] = hold[i];
      if (level[i] >= peak[i]) begin
        peak_upd[i] = level[i];
        hold_upd[i] = HOLD;
      end else if (hold[i] != 8'd0) begin
        hold_upd[i] = hold[i] - 8'd1;
      end else begin
        peak_upd[i] = (level[i] > peak_dec[i]) ? level[i] : peak_dec[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dv_q        <= 1'b0;
      cnt         <= '0;
      ch          <= '0;
      o_send      <= 1'b0;
      o_value     <= 8'd0;
      o_chan      <= 4'd0;
      o_frame_err <= 1'b0;
      o_ovr       <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= 8'd0;
        peak[i]  <= 8'd0;
        hold[i]  <= 8'd0;
      end
    end else begin
      dv_q        <= i_dv;
      o_send      <= (state == SEND) && i_npxl_rdy;
      o_frame_err <= frame_err_nxt;
      o_ovr       <= ovr_nxt;
      case (state)
        IDLE: if (accept && is_sync) cnt <= '0;
        RECV: begin
          if (accept) begin
            if (is_sync) begin
              cnt <= '0;
            end else begin
              level[cnt] <= i_data;
              cnt        <= cnt + 1'b1;
            end
          end
        end
        UPDATE: begin
          ch <= '0;
          for (int i = 0; i < CHANNELS; i++) begin
            peak[i] <= peak_upd[i];
            hold[i] <= hold_upd[i];
          end
        end
        SEND: begin
          if (i_npxl_rdy) begin
            o_value <= peak[ch];
            o_chan  <= 4'(ch);
          end
        end
        WAIT_HI: if (i_npxl_rdy && ch != LAST) ch <= ch + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vu_frame_ctrl.sv
// tb/tb_vu_frame_ctrl.sv - directed self-checking bench for vu_frame_ctrl
module tb_vu_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'd0;
  logic       dv = 1'b0;
  logic       npxl_rdy = 1'b1;
  logic       send;
  logic [7:0] value;
  logic [3:0] chan;
  logic       rdy;
  logic       frame_err;
  logic       ovr;

  int          checks = 0;
  int          errors = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          rdy_cnt = 0;
  logic [11:0] sends[$];

  vu_frame_ctrl #(.CHANNELS(2), .SYNC(8'hFF), .HOLD_FRAMES(2), .DECAY(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_dv(dv), .i_npxl_rdy(npxl_rdy),
    .o_send(send), .o_value(value), .o_chan(chan), .o_rdy(rdy),
    .o_frame_err(frame_err), .o_ovr(ovr)
  );

  always #5 clk = ~clk;

  // pixel controller: drops ready the cycle after o_send, back after 10 cycles
  always @(posedge clk) begin
    if (send) begin
      npxl_rdy <= 1'b0;
      rdy_cnt  <= 10;
    end else if (rdy_cnt > 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) npxl_rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (send)      sends.push_back({chan, value});
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (ovr)       ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data = b;
    dv   = 1'b1;
    @(negedge clk);
    dv   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, rdy, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int b, f0, o0, n;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_send", send, 0);
    check("rst_value", value, 0);
    check("rst_chan", chan, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", rdy, 1);

    // basic frame plus first-send latency
    b = sends.size();
    send_byte(8'hFF);
    send_byte(8'h40);
    @(negedge clk);
    data = 8'h80;
    dv   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dv = 1'b0;
    check("lat_n1", send, 0);
    @(negedge clk);
    check("lat_n2", send, 0);
    @(negedge clk);
    check("lat_n3", send, 1);
    wait_idle("t1_idle");
    check("t1_count", sends.size() - b, 2);
    check("t1_s0", sends[b], 12'h040);
    check("t1_s1", sends[b+1], 12'h180);
    check("t1_hold_val", value, 8'h80);
    check("t1_hold_chan", chan, 1);

    // hold two frames then decay by 16
    do_reset();
    b = sends.size();
    send_byte(8'hFF); send_byte(8'h80); send_byte(8'h00); wait_idle("t2_idle0");
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hFF); send_byte(8'h10); send_byte(8'h00); wait_idle("t2_idle");
    end
    check("t2_count", sends.size() - b, 8);
    check("t2_f0", sends[b],   12'h080);
    check("t2_f1", sends[b+2], 12'h080);
    check("t2_f2", sends[b+4], 12'h080);
    check("t2_f3", sends[b+6], 12'h070);

    // SYNC inside a frame restarts it
    do_reset();
    b  = sends.size();
    f0 = ferr_cnt;
    send_byte(8'hFF); send_byte(8'h40); send_byte(8'hFF);
    send_byte(8'h20); send_byte(8'h30);
    wait_idle("t3_idle");
    check("t3_ferr", ferr_cnt - f0, 1);
    check("t3_count", sends.size() - b, 2);
    check("t3_s0", sends[b], 12'h020);
    check("t3_s1", sends[b+1], 12'h130);

    // byte arriving in WAIT_LO is dropped with an overrun
    b  = sends.size();
    o0 = ovr_cnt;
    send_byte(8'hFF); send_byte(8'h40); send_byte(8'h80);
    n = 0;
    while (!send && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_first_send", send, 1);
    data = 8'h55;
    dv   = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    wait_idle("t4_idle");
    check("t4_ovr", ovr_cnt - o0, 1);
    check("t4_count", sends.size() - b, 2);
    check("t4_s0", sends[b], 12'h040);
    check("t4_s1", sends[b+1], 12'h180);
    b = sends.size();
    send_byte(8'hFF); send_byte(8'h50); send_byte(8'h90);
    wait_idle("t4_idle2");
    check("t4_next0", sends[b], 12'h050);
    check("t4_next1", sends[b+1], 12'h190);

    // reset mid-frame aborts and clears peaks
    b = sends.size();
    send_byte(8'hFF); send_byte(8'h40);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_value", value, 0);
    check("t5_rst_chan", chan, 0);
    check("t5_rst_send", send, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_nosend", sends.size() - b, 0);
    send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
    wait_idle("t5_idle");
    check("t5_count", sends.size() - b, 2);
    check("t5_s0", sends[b], 12'h011);
    check("t5_s1", sends[b+1], 12'h122);

    // long dv pulse counts once
    do_reset();
    b  = sends.size();
    f0 = ferr_cnt;
    @(negedge clk);
    data = 8'hFF;
    dv   = 1'b1;
    repeat (5) @(negedge clk);
    dv = 1'b0;
    send_byte(8'h01); send_byte(8'h02);
    wait_idle("t6_idle");
    check("t6_ferr", ferr_cnt - f0, 0);
    check("t6_count", sends.size() - b, 2);
    check("t6_s0", sends[b], 12'h001);
    check("t6_s1", sends[b+1], 12'h102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
